// File: rtl/life_ctrl_pkg.sv
// life_ctrl_pkg: key indices, controller states and shared helpers for the Life controller
package life_ctrl_pkg;
   localparam int KEYS = 16;
   localparam int KEY_AR_U   = 0;
   localparam int KEY_AR_D   = 1;
   localparam int KEY_AR_L   = 2;
   localparam int KEY_AR_R   = 3;
   localparam int KEY_W      = 4;
   localparam int KEY_A      = 5;
   localparam int KEY_S      = 6;
   localparam int KEY_D      = 7;
   localparam int KEY_IN     = 8;
   localparam int KEY_OUT    = 9;
   localparam int KEY_S_UP   = 10;
   localparam int KEY_S_DOWN = 11;
   localparam int KEY_SPACE  = 12;
   localparam int KEY_ENTER  = 13;
   localparam int KEY_E      = 14;
   localparam int KEY_R      = 15;
   localparam logic [2:0] SPEED_DEFAULT = 3'd3;
   localparam logic [2:0] SPEED_MAX = 3'd7;
   localparam logic [1:0] ZOOM_MAX = 2'd3;
   typedef enum logic [2:0] {PAUSED, RUNNING, STEP_WAIT, WR_WAIT, CLR_WAIT} state_t;
   typedef enum logic [2:0] {CMD_NONE, CMD_R, CMD_SPACE, CMD_ENTER, CMD_E} cmd_t;
   // Coinciding command keys resolve to the single highest-priority one
   function automatic cmd_t decode_cmd(input logic [KEYS-1:0] k);
      return k[KEY_R] ? CMD_R : k[KEY_SPACE] ? CMD_SPACE : k[KEY_ENTER] ? CMD_ENTER : k[KEY_E] ? CMD_E : CMD_NONE;
   endfunction
   // Cycles between run-mode steps: faster speeds give shorter intervals
   function automatic int reload_ticks(input logic [2:0] spd, input int base);
      return (8 - int'(spd)) * base - 1;
   endfunction
endpackage

// File: rtl/life_tick_gen.sv
// life_tick_gen: loadable down-counter timing the interval between run-mode steps
module life_tick_gen
   import life_ctrl_pkg::*;
#(
   parameter int BASE_TICKS = 2_500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       en,
   input  logic [2:0] speed,
   output logic       tc
);
   localparam int CW = $clog2(8 * BASE_TICKS);
   logic [CW-1:0] cnt;
   // Load wins over counting; the count parks at zero until reloaded
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (load) cnt <= CW'(reload_ticks(speed, BASE_TICKS));
      else if (en && cnt != '0) cnt <= cnt - CW'(1);
   assign tc = cnt == '0;
endmodule

// File: rtl/life_ctrl.sv
// life_ctrl: key-driven game controller sequencing the Life engine through step/write/clear handshakes
module life_ctrl
   import life_ctrl_pkg::*;
#(
   parameter int GRID_W     = 64,
   parameter int GRID_H     = 64,
   parameter int XW         = 6,
   parameter int YW         = 6,
   parameter int BASE_TICKS = 2_500_000,
   parameter int GEN_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEYS-1:0]  keys,
   input  logic             step_done,
   input  logic             wr_ack,
   input  logic             clr_done,
   output logic             step_req,
   output logic             wr_req,
   output logic [XW-1:0]    wr_x,
   output logic [YW-1:0]    wr_y,
   output logic             clr_req,
   output logic [XW-1:0]    cur_x,
   output logic [YW-1:0]    cur_y,
   output logic [XW-1:0]    view_x,
   output logic [YW-1:0]    view_y,
   output logic [1:0]       zoom,
   output logic [2:0]       speed,
   output logic             running,
   output logic [GEN_W-1:0] gen_count
);
   state_t state, state_n;
   cmd_t cmd;
   logic pend, pend_n, running_n, step_req_n, wr_req_n, clr_req_n, load, tc;
   logic [XW-1:0] wr_x_n;
   logic [YW-1:0] wr_y_n;
   logic [GEN_W-1:0] gen_n;
   function automatic logic [XW-1:0] wrap_x(input logic [XW-1:0] v, input logic inc, input logic dec);
      return (inc == dec) ? v : inc ? ((v == XW'(GRID_W - 1)) ? '0 : v + XW'(1)) : ((v == '0) ? XW'(GRID_W - 1) : v - XW'(1));
   endfunction
   function automatic logic [YW-1:0] wrap_y(input logic [YW-1:0] v, input logic inc, input logic dec);
      return (inc == dec) ? v : inc ? ((v == YW'(GRID_H - 1)) ? '0 : v + YW'(1)) : ((v == '0) ? YW'(GRID_H - 1) : v - YW'(1));
   endfunction
   assign cmd = decode_cmd(keys);
   life_tick_gen #(.BASE_TICKS(BASE_TICKS)) u_tick (
      .clk(clk),
      .rst(rst),
      .load(load),
      .en(state == RUNNING),
      .speed(speed),
      .tc(tc)
   );
   // Navigation keys act every cycle independent of the controller state
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cur_x  <= '0;
         cur_y  <= '0;
         view_x <= '0;
         view_y <= '0;
         zoom   <= '0;
         speed  <= SPEED_DEFAULT;
      end else begin
         cur_x  <= wrap_x(cur_x, keys[KEY_AR_R], keys[KEY_AR_L]);
         cur_y  <= wrap_y(cur_y, keys[KEY_AR_D], keys[KEY_AR_U]);
         view_x <= wrap_x(view_x, keys[KEY_D], keys[KEY_A]);
         view_y <= wrap_y(view_y, keys[KEY_S], keys[KEY_W]);
         zoom   <= (keys[KEY_IN] && !keys[KEY_OUT] && zoom != ZOOM_MAX) ? zoom + 2'd1 :
                   (keys[KEY_OUT] && !keys[KEY_IN] && zoom != 2'd0) ? zoom - 2'd1 : zoom;
         speed  <= (keys[KEY_S_UP] && !keys[KEY_S_DOWN] && speed != SPEED_MAX) ? speed + 3'd1 :
                   (keys[KEY_S_DOWN] && !keys[KEY_S_UP] && speed != 3'd0) ? speed - 3'd1 : speed;
      end
   // Next-state and next-output decision; only one request can be raised from an idle state
   always_comb begin
      state_n    = state;
      running_n  = running;
      step_req_n = step_req;
      wr_req_n   = wr_req;
      clr_req_n  = clr_req;
      wr_x_n     = wr_x;
      wr_y_n     = wr_y;
      gen_n      = gen_count;
      pend_n     = pend;
      load       = 1'b0;
      case (state)
         PAUSED:
            if (cmd == CMD_R) begin
               state_n   = CLR_WAIT;
               clr_req_n = 1'b1;
            end else if (cmd == CMD_SPACE) begin
               state_n   = RUNNING;
               running_n = 1'b1;
               load      = 1'b1;
            end else if (cmd == CMD_ENTER) begin
               state_n    = STEP_WAIT;
               step_req_n = 1'b1;
            end else if (cmd == CMD_E) begin
               state_n  = WR_WAIT;
               wr_req_n = 1'b1;
               wr_x_n   = cur_x;
               wr_y_n   = cur_y;
            end
         RUNNING:
            if (cmd == CMD_R) begin
               state_n   = CLR_WAIT;
               running_n = 1'b0;
               clr_req_n = 1'b1;
            end else if (cmd == CMD_SPACE) begin
               state_n   = PAUSED;
               running_n = 1'b0;
            end else if (tc) begin
               state_n    = STEP_WAIT;
               step_req_n = 1'b1;
               load       = 1'b1;
            end
         STEP_WAIT: begin
            pend_n = pend | (cmd == CMD_R);
            if (cmd == CMD_SPACE) running_n = !running;
            if (step_done) begin
               step_req_n = 1'b0;
               gen_n      = gen_count + GEN_W'(1);
               if (pend_n) begin
                  state_n   = CLR_WAIT;
                  clr_req_n = 1'b1;
                  running_n = 1'b0;
               end else state_n = running_n ? RUNNING : PAUSED;
            end
         end
         WR_WAIT: begin
            pend_n = pend | (cmd == CMD_R);
            if (wr_ack) begin
               wr_req_n  = 1'b0;
               clr_req_n = pend_n;
               state_n   = pend_n ? CLR_WAIT : PAUSED;
            end
         end
         CLR_WAIT:
            if (clr_done) begin
               clr_req_n = 1'b0;
               gen_n     = '0;
               pend_n    = 1'b0;
               state_n   = PAUSED;
            end
         default: state_n = PAUSED;
      endcase
   end
   // Controller state and all handshake outputs are registered
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= PAUSED;
         running   <= 1'b0;
         step_req  <= 1'b0;
         wr_req    <= 1'b0;
         clr_req   <= 1'b0;
         wr_x      <= '0;
         wr_y      <= '0;
         gen_count <= '0;
         pend      <= 1'b0;
      end else begin
         state     <= state_n;
         running   <= running_n;
         step_req  <= step_req_n;
         wr_req    <= wr_req_n;
         clr_req   <= clr_req_n;
         wr_x      <= wr_x_n;
         wr_y      <= wr_y_n;
         gen_count <= gen_n;
         pend      <= pend_n;
      end
endmodule

// File: tb/tb_life_ctrl.sv
// tb_life_ctrl: scoreboard bench comparing life_ctrl against a behavioural game model
module tb_life_ctrl;
   import life_ctrl_pkg::*;
   localparam int BT = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [15:0] keys = '0;
   logic step_done = 1'b0, wr_ack = 1'b0, clr_done = 1'b0;
   logic step_req, wr_req, clr_req, running;
   logic [5:0] wr_x, wr_y, cur_x, cur_y, view_x, view_y;
   logic [1:0] zoom;
   logic [2:0] speed;
   logic [15:0] gen_count;
   logic [60:0] act_v;
   typedef struct {
      logic [60:0] v;
      string tag;
   } exp_t;
   exp_t sb[$];
   exp_t e;
   int errors = 0, checks = 0, cyc = 0;
   string phase = "reset";
   int m_cx, m_cy, m_vx, m_vy, m_zoom, m_speed, m_gen, m_cnt, m_wx, m_wy;
   bit m_run, m_sreq, m_wreq, m_creq, m_pend;
   int age, r1, r2, ndone;
   logic sd, prev;

   life_ctrl #(.GRID_W(64), .GRID_H(64), .XW(6), .YW(6), .BASE_TICKS(BT), .GEN_W(16)) dut (
      .clk(clk), .rst(rst), .keys(keys), .step_done(step_done), .wr_ack(wr_ack), .clr_done(clr_done),
      .step_req(step_req), .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .clr_req(clr_req),
      .cur_x(cur_x), .cur_y(cur_y), .view_x(view_x), .view_y(view_y), .zoom(zoom), .speed(speed),
      .running(running), .gen_count(gen_count)
   );

   always #5 clk = ~clk;
   assign act_v = {cur_x, cur_y, view_x, view_y, zoom, speed, running, step_req, wr_req, clr_req, wr_x, wr_y, gen_count};

   function automatic int b(input logic x);
      return x ? 1 : 0;
   endfunction

   function automatic logic [15:0] kb(input int i);
      return 16'(1) << i;
   endfunction

   function automatic void model_reset();
      m_cx = 0; m_cy = 0; m_vx = 0; m_vy = 0; m_zoom = 0; m_speed = 3; m_gen = 0; m_cnt = 0;
      m_wx = 0; m_wy = 0; m_run = 0; m_sreq = 0; m_wreq = 0; m_creq = 0; m_pend = 0;
   endfunction

   // One clock of the game rules: commands see the values before this edge's navigation
   function automatic void model_step(input logic [15:0] k, input logic sdn, input logic wa, input logic cd);
      bit r, sp, en, ek;
      r  = k[KEY_R];
      sp = !r && k[KEY_SPACE];
      en = !r && !sp && k[KEY_ENTER];
      ek = !r && !sp && !en && k[KEY_E];
      if (m_sreq) begin
         if (r) m_pend = 1;
         if (sp) m_run = !m_run;
         if (sdn) begin
            m_sreq = 0;
            m_gen = (m_gen + 1) % 65536;
            if (m_pend) begin m_creq = 1; m_run = 0; end
         end
      end else if (m_wreq) begin
         if (r) m_pend = 1;
         if (wa) begin m_wreq = 0; if (m_pend) m_creq = 1; end
      end else if (m_creq) begin
         if (cd) begin m_creq = 0; m_gen = 0; m_pend = 0; end
      end else if (m_run) begin
         if (m_cnt == 0 && !r && !sp) begin m_sreq = 1; m_cnt = (8 - m_speed) * BT - 1; end
         else if (m_cnt > 0) m_cnt--;
         if (r) begin m_run = 0; m_creq = 1; end
         else if (sp) m_run = 0;
      end else begin
         if (r) m_creq = 1;
         else if (sp) begin m_run = 1; m_cnt = (8 - m_speed) * BT - 1; end
         else if (en) m_sreq = 1;
         else if (ek) begin m_wreq = 1; m_wx = m_cx; m_wy = m_cy; end
      end
      m_cx = (m_cx + b(k[KEY_AR_R]) - b(k[KEY_AR_L]) + 64) % 64;
      m_cy = (m_cy + b(k[KEY_AR_D]) - b(k[KEY_AR_U]) + 64) % 64;
      m_vx = (m_vx + b(k[KEY_D]) - b(k[KEY_A]) + 64) % 64;
      m_vy = (m_vy + b(k[KEY_S]) - b(k[KEY_W]) + 64) % 64;
      if (b(k[KEY_IN]) > b(k[KEY_OUT]) && m_zoom < 3) m_zoom++;
      else if (b(k[KEY_OUT]) > b(k[KEY_IN]) && m_zoom > 0) m_zoom--;
      if (b(k[KEY_S_UP]) > b(k[KEY_S_DOWN]) && m_speed < 7) m_speed++;
      else if (b(k[KEY_S_DOWN]) > b(k[KEY_S_UP]) && m_speed > 0) m_speed--;
   endfunction

   function automatic logic [60:0] m_pack();
      return {6'(m_cx), 6'(m_cy), 6'(m_vx), 6'(m_vy), 2'(m_zoom), 3'(m_speed), m_run, m_sreq, m_wreq, m_creq,
              6'(m_wx), 6'(m_wy), 16'(m_gen)};
   endfunction

   task automatic cycle(input logic [15:0] k, input logic sdn, input logic wa, input logic cd);
      keys = k; step_done = sdn; wr_ack = wa; clr_done = cd;
      @(posedge clk);
      model_step(k, sdn, wa, cd);
      sb.push_back('{v: m_pack(), tag: phase});
      #1;
      keys = '0; step_done = 1'b0; wr_ack = 1'b0; clr_done = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle('0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pulse(input int i);
      cycle(kb(i), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every registered output snapshot is compared half a cycle after the edge
   always @(negedge clk) begin
      cyc++;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (act_v !== e.v) begin
            errors++;
            $display("FAIL %s at cycle %0d: outputs got %h, expected %h", e.tag, cyc, act_v, e.v);
         end
      end
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_speed", int'(speed), 3);
      chk("rst_cur_x", int'(cur_x), 0);
      chk("rst_running", int'(running), 0);
      chk("rst_reqs", int'({step_req, wr_req, clr_req}), 0);

      phase = "nav";
      repeat (3) pulse(KEY_AR_L);
      chk("cur_x_wrap_left", int'(cur_x), 61);
      pulse(KEY_AR_U);
      chk("cur_y_wrap_up", int'(cur_y), 63);
      repeat (5) pulse(KEY_IN);
      chk("zoom_saturate", int'(zoom), 3);
      repeat (8) pulse(KEY_AR_R);
      repeat (8) pulse(KEY_AR_D);
      chk("cur_x_wrap_right", int'(cur_x), 5);
      chk("cur_y_wrap_down", int'(cur_y), 7);
      cycle(kb(KEY_AR_L) | kb(KEY_AR_R), 1'b0, 1'b0, 1'b0);
      chk("opposing_cancel", int'(cur_x), 5);

      phase = "toggle";
      pulse(KEY_E);
      chk("wr_req_rise", int'(wr_req), 1);
      chk("wr_x_latch", int'(wr_x), 5);
      chk("wr_y_latch", int'(wr_y), 7);
      idle(4);
      chk("wr_req_held", int'(wr_req), 1);
      cycle('0, 1'b0, 1'b1, 1'b0);
      chk("wr_req_drop", int'(wr_req), 0);
      chk("wr_back_paused", int'(running), 0);

      phase = "run_period";
      repeat (5) pulse(KEY_S_UP);
      chk("speed_saturate", int'(speed), 7);
      pulse(KEY_SPACE);
      chk("running_set", int'(running), 1);
      age = 0; prev = 1'b0; r1 = -1; r2 = -1; ndone = 0;
      for (int i = 1; i <= 30; i++) begin
         sd = m_sreq && age == 3;
         ndone += int'(sd);
         cycle('0, sd, 1'b0, 1'b0);
         age = m_sreq ? age + 1 : 0;
         if (step_req && !prev) begin
            if (r1 < 0) r1 = i;
            else if (r2 < 0) r2 = i;
         end
         prev = step_req;
      end
      chk("first_step_delay", r1, 4);
      chk("step_period", r2 - r1, 7);
      chk("gen_after_run", int'(gen_count), ndone);

      phase = "clear_from_step";
      for (int i = 0; i < 20 && !m_sreq; i++) idle(1);
      chk("step_req_before_r", int'(step_req), 1);
      pulse(KEY_R);
      chk("clr_deferred", int'(clr_req), 0);
      cycle('0, 1'b1, 1'b0, 1'b0);
      ndone++;
      chk("clr_after_step", int'(clr_req), 1);
      chk("run_forced_off", int'(running), 0);
      chk("step_req_drop", int'(step_req), 0);
      idle(3);
      chk("gen_before_clear", int'(gen_count), ndone);
      cycle('0, 1'b0, 1'b0, 1'b1);
      chk("gen_cleared", int'(gen_count), 0);
      chk("clr_req_drop", int'(clr_req), 0);

      phase = "r_beats_space";
      cycle(kb(KEY_R) | kb(KEY_SPACE), 1'b0, 1'b0, 1'b0);
      chk("r_space_clear", int'(clr_req), 1);
      chk("r_space_no_run", int'(running), 0);
      idle(2);
      cycle('0, 1'b0, 1'b0, 1'b1);
      chk("r_space_done", int'(clr_req), 0);

      phase = "async_reset";
      pulse(KEY_E);
      idle(2);
      chk("wr_wait_entered", int'(wr_req), 1);
      #6 rst = 1'b1;
      #1;
      chk("arst_reqs", int'({step_req, wr_req, clr_req}), 0);
      chk("arst_cursor", int'({cur_x, cur_y}), 0);
      chk("arst_speed", int'(speed), 3);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      phase = "random";
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] k;
         logic s, w, c;
         k = 16'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 3) != 0) k[15:12] = '0;
         s = m_sreq ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         w = m_wreq ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         c = m_creq ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         cycle(k, s, w, c);
      end

      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
